conv_window_gen: RTL and testbench

Streaming 3x3 window generator that sits directly upstream of the Conv2D stage. It accepts one 8-bit pixel per handshake in raster order, buffers two image lines, and emits one zero-padded 3x3 window per output pixel position ("same" convolution: IMG_H x IMG_W windows per frame). It gives Conv2D a ready-made neighbourhood, so that stage no longer indexes the image itself.

---
 rtl/conv_pkg.sv | 17 +
 rtl/line_buffer.sv | 25 ++
 rtl/conv_window_gen.sv | 150 +++++++++++++++
 tb/tb_conv_window_gen.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 window generator.
package conv_pkg;

    localparam int PIX_W    = 8;
    localparam int WIN_TAPS = 9;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    function automatic int idx(input int ky, input int kx);
        return ky * 3 + kx;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of delay: a DEPTH-deep shift buffer, read-before-write on shift.
module line_buffer #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (shift_i) begin
            mem_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming zero-padded 3x3 window generator ("same" convolution) feeding Conv2D.
module conv_window_gen #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = conv_pkg::PIX_W
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [PIX_W-1:0]                  in_pixel_i,
    output logic                              win_valid_o,
    input  logic                              win_ready_i,
    output logic [conv_pkg::WIN_TAPS*PIX_W-1:0] win_data_o,
    output logic [$clog2(IMG_H)-1:0]          win_row_o,
    output logic [$clog2(IMG_W)-1:0]          win_col_o,
    output logic                              frame_done_o,
    output conv_pkg::state_t                  state_o
);
    import conv_pkg::*;

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

    state_t                      state_q;
    logic [RW-1:0]               in_row_q, out_row_q, win_row_q;
    logic [CW-1:0]               in_col_q, out_col_q, win_col_q;
    logic                        win_valid_q;
    logic [WIN_TAPS*PIX_W-1:0]   win_data_q, win_d;
    logic [PIX_W-1:0]            tap_q [3][3];
    logic [PIX_W-1:0]            tap_d [3][3];
    logic [PIX_W-1:0]            new_col [3];
    logic [PIX_W-1:0]            new_pix, lb1_out, lb2_out;
    logic                        out_free, in_fire, flush_load, shift, load, win_fire, frame_done;

    always_comb begin
        out_free   = !win_valid_q || win_ready_i;
        in_ready_o = (state_q != FLUSH) && out_free;
        in_fire    = in_valid_i && in_ready_o;
        // Out counters wrap to (0,0) once the final window is loaded, which ends the flush.
        flush_load = (state_q == FLUSH) && out_free && !(out_row_q == '0 && out_col_q == '0);
        shift      = in_fire || flush_load;
        load       = ((state_q == STREAM) && in_fire) || flush_load;
        win_fire   = win_valid_q && win_ready_i;
        frame_done = win_fire && (state_q == FLUSH) && (win_row_q == ROW_LAST) && (win_col_q == COL_LAST);
        new_pix    = (state_q == FLUSH) ? '0 : in_pixel_i;
    end

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk_i   (clk_i),
        .shift_i (shift),
        .din_i   (new_pix),
        .dout_o  (lb1_out)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
        .clk_i   (clk_i),
        .shift_i (shift),
        .din_i   (lb1_out),
        .dout_o  (lb2_out)
    );

    // The right tap column is the newest pixel plus the same column one and two lines up.
    always_comb begin
        new_col[0] = lb2_out;
        new_col[1] = lb1_out;
        new_col[2] = new_pix;
        for (int ky = 0; ky < 3; ky++) begin
            tap_d[ky][0] = tap_q[ky][1];
            tap_d[ky][1] = tap_q[ky][2];
            tap_d[ky][2] = new_col[ky];
        end
    end

    always_comb begin
        win_d = '0;
        for (int ky = 0; ky < 3; ky++) begin
            for (int kx = 0; kx < 3; kx++) begin
                if (!((ky == 0 && out_row_q == '0) || (ky == 2 && out_row_q == ROW_LAST) ||
                      (kx == 0 && out_col_q == '0) || (kx == 2 && out_col_q == COL_LAST))) begin
                    win_d[idx(ky, kx)*PIX_W +: PIX_W] = tap_d[ky][kx];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= FILL;
            in_row_q    <= '0;
            in_col_q    <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
            for (int ky = 0; ky < 3; ky++) begin
                for (int kx = 0; kx < 3; kx++) begin
                    tap_q[ky][kx] <= '0;
                end
            end
        end else begin
            if (shift) begin
                tap_q <= tap_d;
            end

            if (load) begin
                win_valid_q <= 1'b1;
                win_data_q  <= win_d;
                win_row_q   <= out_row_q;
                win_col_q   <= out_col_q;
                if (out_col_q == COL_LAST) begin
                    out_col_q <= '0;
                    out_row_q <= (out_row_q == ROW_LAST) ? '0 : out_row_q + 1'b1;
                end else begin
                    out_col_q <= out_col_q + 1'b1;
                end
            end else if (win_fire) begin
                win_valid_q <= 1'b0;
            end

            if (in_fire) begin
                if (in_col_q == COL_LAST) begin
                    in_col_q <= '0;
                    in_row_q <= (in_row_q == ROW_LAST) ? '0 : in_row_q + 1'b1;
                end else begin
                    in_col_q <= in_col_q + 1'b1;
                end
            end

            case (state_q)
                FILL:    if (in_fire && in_row_q == RW'(1) && in_col_q == '0) state_q <= STREAM;
                STREAM:  if (in_fire && in_row_q == ROW_LAST && in_col_q == COL_LAST) state_q <= FLUSH;
                FLUSH:   if (frame_done) state_q <= FILL;
                default: state_q <= FILL;
            endcase
        end
    end

    assign win_valid_o  = win_valid_q;
    assign win_data_o   = win_data_q;
    assign win_row_o    = win_row_q;
    assign win_col_o    = win_col_q;
    assign frame_done_o = frame_done;
    assign state_o      = state_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 4x3 image with pixel (r,c) = r*4+c+1.
module tb_conv_window_gen;
  import conv_pkg::*;

  localparam int W = 4;
  localparam int H = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_pixel = '0;
  logic        win_valid;
  logic        win_ready = 1'b1;
  logic [71:0] win_data;
  logic [1:0]  win_row;
  logic [1:0]  win_col;
  logic        frame_done;
  state_t      state;

  int n_checks = 0;
  int n_errors = 0;
  int win_cnt = 0;
  int frame_cnt = 0;
  bit rand_ready = 1'b0;
  logic [75:0] exp_q[$];
  logic [71:0] captured [H][W];
  logic [71:0] first_win [16];

  conv_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_pixel_i   (in_pixel),
    .win_valid_o  (win_valid),
    .win_ready_i  (win_ready),
    .win_data_o   (win_data),
    .win_row_o    (win_row),
    .win_col_o    (win_col),
    .frame_done_o (frame_done),
    .state_o      (state)
  );

  // clock / reset / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [75:0] got, input logic [75:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] w9(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    return {8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  function automatic logic [71:0] gold(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int ky = 0; ky < 3; ky++) begin
      for (int kx = 0; kx < 3; kx++) begin
        int rr;
        int cc;
        rr = r + ky - 1;
        cc = c + kx - 1;
        if (rr >= 0 && rr < H && cc >= 0 && cc < W) w[(ky*3+kx)*8 +: 8] = 8'(rr*W + cc + 1);
      end
    end
    return w;
  endfunction

  // scoreboard
  task automatic push_expected();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        exp_q.push_back({2'(r), 2'(c), gold(r, c)});
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (win_valid && win_ready) begin
        win_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_window", {win_row, win_col, win_data}, '1);
        end else begin
          chk("window", {win_row, win_col, win_data}, exp_q.pop_front());
        end
        captured[win_row][win_col] = win_data;
        if (win_row == 0 && win_col == 0 && frame_cnt < 16) first_win[frame_cnt] = win_data;
      end
      if (frame_done || (win_valid && win_ready && win_row == 2'(H-1) && win_col == 2'(W-1))) begin
        chk("frame_done_align", 76'(frame_done), 76'(1));
        if (frame_done) frame_cnt++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) win_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // drivers
  task automatic push_pixel(input logic [7:0] p);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_pixel = p;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("in_ready_timeout", 76'(in_ready), 76'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap_max);
    for (int p = 1; p <= W*H; p++) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
      push_pixel(8'(p));
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("drain_left", 76'(exp_q.size()), 76'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w0;
    int f0;
    int fires;
    int t;
    bit done;

    // reset state
    #12;
    chk("rst_win_valid", 76'(win_valid), 76'(0));
    chk("rst_win_data", 76'(win_data), 76'(0));
    chk("rst_row_col", 76'({win_row, win_col}), 76'(0));
    chk("rst_frame_done", 76'(frame_done), 76'(0));
    chk("rst_state", 76'(state), 76'(FILL));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // scenario 1/2: full frame, no back-pressure
    w0 = win_cnt;
    f0 = frame_cnt;
    push_expected();
    for (int p = 1; p <= 5; p++) begin
      push_pixel(8'(p));
      chk("fill_no_window", 76'(win_valid), 76'(0));
    end
    push_pixel(8'd6);
    chk("first_valid", 76'(win_valid), 76'(1));
    chk("first_window", 76'(win_data), 76'(w9(0, 0, 0, 0, 1, 2, 0, 5, 6)));
    for (int p = 7; p <= 12; p++) push_pixel(8'(p));
    wait_drain();
    chk("frame1_windows", 76'(win_cnt - w0), 76'(12));
    chk("frame1_done_pulses", 76'(frame_cnt - f0), 76'(1));
    chk("win_1_1", 76'(captured[1][1]), 76'(w9(1, 2, 3, 5, 6, 7, 9, 10, 11)));
    chk("win_2_3", 76'(captured[2][3]), 76'(w9(7, 8, 0, 11, 12, 0, 0, 0, 0)));
    chk("win_0_3", 76'(captured[0][3]), 76'(w9(0, 0, 0, 3, 4, 0, 7, 8, 0)));
    chk("idle_state", 76'(state), 76'(FILL));

    // scenario 3: hold at window (1,0)
    w0 = win_cnt;
    push_expected();
    for (int p = 1; p <= 10; p++) push_pixel(8'(p));
    win_ready = 1'b0;
    chk("hold_rowcol", 76'({win_row, win_col}), 76'({2'd1, 2'd0}));
    in_valid = 1'b1;
    in_pixel = 8'd11;
    repeat (5) begin
      @(negedge clk);
      chk("hold_in_ready", 76'(in_ready), 76'(0));
      chk("hold_data", 76'(win_data), 76'(w9(0, 1, 2, 0, 5, 6, 0, 9, 10)));
    end
    @(posedge clk);
    #1;
    win_ready = 1'b1;
    push_pixel(8'd11);
    push_pixel(8'd12);

    // scenario 6: in_valid held high through FLUSH
    in_valid = 1'b1;
    in_pixel = 8'hAA;
    fires = 0;
    done = 1'b0;
    t = 0;
    while (!done && t < 40) begin
      @(negedge clk);
      t++;
      chk("flush_in_ready", 76'(in_ready), 76'(0));
      if (win_valid && win_ready) fires++;
      if (frame_done) begin
        done = 1'b1;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("flush_done_seen", 76'(done), 76'(1));
    chk("flush_windows", 76'(fires - 1), 76'(5));
    wait_drain();
    chk("frame2_windows", 76'(win_cnt - w0), 76'(12));

    // scenario 4: three back-to-back frames with random gaps
    f0 = frame_cnt;
    w0 = win_cnt;
    rand_ready = 1'b1;
    push_expected();
    push_expected();
    push_expected();
    send_frame(2);
    send_frame(2);
    send_frame(2);
    wait_drain();
    rand_ready = 1'b0;
    win_ready = 1'b1;
    t = 0;
    while (frame_cnt - f0 < 3 && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    chk("rand_frames", 76'(frame_cnt - f0), 76'(3));
    chk("rand_windows", 76'(win_cnt - w0), 76'(36));
    chk("frame_b_first", 76'(first_win[f0+1]), 76'(w9(0, 0, 0, 0, 1, 2, 0, 5, 6)));

    // scenario 5: reset after pixel 8
    push_expected();
    for (int p = 1; p <= 8; p++) push_pixel(8'(p));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 76'(win_valid), 76'(0));
    chk("mid_rst_data", 76'(win_data), 76'(0));
    chk("mid_rst_rowcol", 76'({win_row, win_col}), 76'(0));
    chk("mid_rst_state", 76'(state), 76'(FILL));
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    w0 = win_cnt;
    push_expected();
    send_frame(0);
    wait_drain();
    chk("post_rst_windows", 76'(win_cnt - w0), 76'(12));
    chk("post_rst_first", 76'(captured[0][0]), 76'(w9(0, 0, 0, 0, 1, 2, 0, 5, 6)));

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
